// File: rtl/reg_to_apb_pkg.sv
// rtl/reg_to_apb_pkg.sv - shared helpers for the REG_BUS to APB4 bridge
package reg_to_apb_pkg;

  localparam logic [2:0] PprotDefault = 3'b000;

  // A disabled timeout still needs a one-bit counter so the logic stays well-formed.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout_cycles);
    int unsigned w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_bus.sv
// rtl/reg_bus.sv - register-bus request/response bundle
interface REG_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    write;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    error;
  logic                    ready;

  modport in  (input addr, write, wdata, wstrb, valid, output rdata, error, ready);
  modport out (output addr, write, wdata, wstrb, valid, input rdata, error, ready);
endinterface

// File: rtl/reg_to_apb.sv
// rtl/reg_to_apb.sv - REG_BUS responder to APB4 initiator bridge with wait-state timeout
module reg_to_apb
  import reg_to_apb_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  REG_BUS.in                     reg_i,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  output logic [2:0]             pprot_o,
  input  logic [DataWidth-1:0]   prdata_i,
  input  logic                   pready_i,
  input  logic                   pslverr_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntWidth  = wait_cnt_width(TimeoutCycles);
  localparam logic [CntWidth-1:0] CntLast =
    (TimeoutCycles == 0) ? '0 : CntWidth'(TimeoutCycles - 1);
  localparam logic [CntWidth-1:0] CntSat = '1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0] wstrb_q, wstrb_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 error_q, error_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    error_d = error_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (reg_i.valid) begin
          addr_d  = reg_i.addr;
          write_d = reg_i.write;
          wdata_d = reg_i.wdata;
          wstrb_d = reg_i.wstrb;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        // A completion arriving in the last allowed cycle beats the timeout.
        if (pready_i) begin
          rdata_d = write_q ? '0 : prdata_i;
          error_d = pslverr_i;
          state_d = StResp;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
          rdata_d = '0;
          error_d = 1'b1;
          state_d = StResp;
        end else if (cnt_q != CntSat) begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  // APB request fields come only from the capture registers so they hold through ACCESS.
  assign paddr_o   = addr_q;
  assign pwrite_o  = write_q;
  assign pwdata_o  = wdata_q;
  assign pstrb_o   = write_q ? wstrb_q : '0;
  assign pprot_o   = PprotDefault;
  assign psel_o    = (state_q == StSetup) || (state_q == StAccess);
  assign penable_o = (state_q == StAccess);

  assign reg_i.ready = (state_q == StResp);
  assign reg_i.rdata = rdata_q;
  assign reg_i.error = error_q;

endmodule

// File: tb/tb_reg_to_apb.sv
// tb/tb_reg_to_apb.sv - self-checking bench for reg_to_apb
module tb_reg_to_apb;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] req_addr, req_wdata;
  logic        req_write, req_valid;
  logic [3:0]  req_wstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  REG_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) r0 ();
  REG_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) r1 ();

  assign r0.addr  = req_addr;
  assign r0.write = req_write;
  assign r0.wdata = req_wdata;
  assign r0.wstrb = req_wstrb;
  assign r0.valid = req_valid & ~sel;
  assign r1.addr  = req_addr;
  assign r1.write = req_write;
  assign r1.wdata = req_wdata;
  assign r1.wstrb = req_wstrb;
  assign r1.valid = req_valid & sel;

  logic [31:0] paddr0, paddr1, pwdata0, pwdata1;
  logic        psel0, psel1, penable0, penable1, pwrite0, pwrite1;
  logic [3:0]  pstrb0, pstrb1;
  logic [2:0]  pprot0, pprot1;

  // dut0 has the timeout disabled, dut1 aborts after 4 ACCESS cycles
  reg_to_apb #(.DataWidth(32), .AddrWidth(32), .TimeoutCycles(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .reg_i(r0),
    .paddr_o(paddr0), .psel_o(psel0), .penable_o(penable0), .pwrite_o(pwrite0),
    .pwdata_o(pwdata0), .pstrb_o(pstrb0), .pprot_o(pprot0),
    .prdata_i(prdata), .pready_i(pready & ~sel), .pslverr_i(pslverr)
  );

  reg_to_apb #(.DataWidth(32), .AddrWidth(32), .TimeoutCycles(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .reg_i(r1),
    .paddr_o(paddr1), .psel_o(psel1), .penable_o(penable1), .pwrite_o(pwrite1),
    .pwdata_o(pwdata1), .pstrb_o(pstrb1), .pprot_o(pprot1),
    .prdata_i(prdata), .pready_i(pready & sel), .pslverr_i(pslverr)
  );

  logic [31:0] o_paddr, o_pwdata, o_rdata;
  logic        o_psel, o_penable, o_pwrite, o_ready, o_error;
  logic [3:0]  o_pstrb;
  logic [2:0]  o_pprot;
  assign o_paddr   = sel ? paddr1   : paddr0;
  assign o_pwdata  = sel ? pwdata1  : pwdata0;
  assign o_psel    = sel ? psel1    : psel0;
  assign o_penable = sel ? penable1 : penable0;
  assign o_pwrite  = sel ? pwrite1  : pwrite0;
  assign o_pstrb   = sel ? pstrb1   : pstrb0;
  assign o_pprot   = sel ? pprot1   : pprot0;
  assign o_rdata   = sel ? r1.rdata : r0.rdata;
  assign o_error   = sel ? r1.error : r0.error;
  assign o_ready   = sel ? r1.ready : r0.ready;

  // Requester plus APB completer: answers after `waits` wait states (-1 = never).
  task automatic run_xfer(
    input  logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] ws,
    input  int waits, input logic [31:0] rd, input logic se, input int max_c, input bit hold,
    output int rc, output int rcyc, output int psel_c, output logic [31:0] rdo, output logic eo,
    output int n_setup, output int n_access, output bit stable);
    rc = -1; rcyc = -1; psel_c = -1; rdo = '0; eo = 1'b0;
    n_setup = 0; n_access = 0; stable = 1'b1;
    req_addr = a; req_write = w; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      if (o_ready) begin
        rc = c; rcyc = cyc; rdo = o_rdata; eo = o_error;
        break;
      end
      if (o_psel && psel_c < 0) psel_c = c;
      if (o_psel && !o_penable) n_setup++;
      if (o_psel && o_penable) n_access++;
      if (o_psel && (o_paddr !== a || o_pwrite !== w || o_pwdata !== wd ||
                     o_pstrb !== (w ? ws : 4'h0))) stable = 1'b0;
      if (o_psel && o_penable && (n_access - 1) == waits) begin
        pready = 1'b1; prdata = rd; pslverr = se;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end
    end
    pready = 1'b0; pslverr = 1'b0;
    if (!hold) begin
      req_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      vectors++;
      if ({o_psel, o_penable, o_pwrite, o_ready, o_error} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_ctrl dut%0d got %b want 00000", s, {o_psel, o_penable, o_pwrite, o_ready, o_error});
      end
      vectors++;
      if ({o_paddr, o_pwdata, o_pstrb, o_pprot} !== 71'b0) begin
        miscompares++;
        $display("FAIL reset_bus dut%0d got paddr=%h pwdata=%h pstrb=%h pprot=%h want all 0", s, o_paddr, o_pwdata, o_pstrb, o_pprot);
      end
      vectors++;
      if (o_rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rdata dut%0d got %h want 0", s, o_rdata);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_zero_wait_write();
    int rc, rcyc, pc, ns, na; logic [31:0] rdo; logic eo; bit st;
    sel = 1'b0;
    run_xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 20, 1'b0, rc, rcyc, pc, rdo, eo, ns, na, st);
    vectors++;
    if (rc !== 3) begin miscompares++; $display("FAIL zw_ready_cycle got %0d want 3", rc); end
    vectors++;
    if (pc !== 1) begin miscompares++; $display("FAIL zw_psel_cycle got %0d want 1", pc); end
    vectors++;
    if (ns !== 1 || na !== 1) begin miscompares++; $display("FAIL zw_phases got setup=%0d access=%0d want 1/1", ns, na); end
    vectors++;
    if (st !== 1'b1) begin miscompares++; $display("FAIL zw_bus_stable got %0d want 1", st); end
    vectors++;
    if (eo !== 1'b0) begin miscompares++; $display("FAIL zw_error got %0d want 0", eo); end
  endtask

  task automatic test_wait_read();
    int rc, rcyc, pc, ns, na; logic [31:0] rdo; logic eo; bit st;
    sel = 1'b0;
    run_xfer(32'h20, 1'b0, $urandom, 4'($urandom), 3, 32'h12345678, 1'b0, 20, 1'b0, rc, rcyc, pc, rdo, eo, ns, na, st);
    vectors++;
    if (rc !== 6) begin miscompares++; $display("FAIL wr_ready_cycle got %0d want 6", rc); end
    vectors++;
    if (rdo !== 32'h12345678) begin miscompares++; $display("FAIL wr_rdata got %h want 12345678", rdo); end
    vectors++;
    if (na !== 4) begin miscompares++; $display("FAIL wr_access_cycles got %0d want 4", na); end
    vectors++;
    if (st !== 1'b1) begin miscompares++; $display("FAIL wr_bus_stable_pstrb0 got %0d want 1", st); end
  endtask

  task automatic test_slverr();
    int rc, rcyc, pc, ns, na; logic [31:0] rdo; logic eo; bit st; logic [31:0] d;
    sel = 1'b0;
    run_xfer(32'h30, 1'b1, 32'hA5A5_0F0F, 4'h3, 1, 32'h0, 1'b1, 20, 1'b0, rc, rcyc, pc, rdo, eo, ns, na, st);
    vectors++;
    if (rc !== 4 || eo !== 1'b1) begin miscompares++; $display("FAIL slverr_resp got cycle=%0d err=%0d want 4/1", rc, eo); end
    d = $urandom;
    run_xfer(32'h34, 1'b0, 32'h0, 4'h0, 0, d, 1'b0, 20, 1'b0, rc, rcyc, pc, rdo, eo, ns, na, st);
    vectors++;
    if (rc !== 3 || eo !== 1'b0 || rdo !== d) begin
      miscompares++;
      $display("FAIL slverr_next got cycle=%0d err=%0d rdata=%h want 3/0/%h", rc, eo, rdo, d);
    end
  endtask

  task automatic test_timeout();
    int rc, rcyc, pc, ns, na; logic [31:0] rdo; logic eo; bit st;
    sel = 1'b1;
    run_xfer(32'h40, 1'b0, 32'h0, 4'h0, -1, 32'h0, 1'b0, 20, 1'b0, rc, rcyc, pc, rdo, eo, ns, na, st);
    vectors++;
    if (na !== 4) begin miscompares++; $display("FAIL to_access_cycles got %0d want 4", na); end
    vectors++;
    if (rc !== 6 || eo !== 1'b1 || rdo !== 32'h0) begin
      miscompares++;
      $display("FAIL to_resp got cycle=%0d err=%0d rdata=%h want 6/1/0", rc, eo, rdo);
    end
    sel = 1'b0;
    run_xfer(32'h44, 1'b0, 32'h0, 4'h0, -1, 32'h0, 1'b0, 100, 1'b0, rc, rcyc, pc, rdo, eo, ns, na, st);
    vectors++;
    if (rc !== -1 || na !== 99) begin
      miscompares++;
      $display("FAIL noto_hang got ready_cycle=%0d access=%0d want -1/99", rc, na);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    int rc, rcyc, pc, ns, na; logic [31:0] rdo; logic eo; bit st; bit seen; logic [31:0] d;
    sel = 1'b0;
    req_addr = 32'h50; req_write = 1'b0; req_valid = 1'b1; pready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (o_psel !== 1'b1 || o_penable !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_access got psel=%0d penable=%0d want 1/1", o_psel, o_penable);
    end
    rst = 1'b1; pready = 1'b1; prdata = 32'hFFFF_0000;
    @(negedge clk);
    vectors++;
    if (o_psel !== 1'b0 || o_penable !== 1'b0 || o_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_abort got psel=%0d penable=%0d ready=%0d want 0/0/0", o_psel, o_penable, o_ready);
    end
    rst = 1'b0; pready = 1'b0; req_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_ready) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_no_ready got %0d want 0", seen); end
    d = $urandom;
    run_xfer(32'h54, 1'b0, 32'h0, 4'h0, 1, d, 1'b0, 20, 1'b0, rc, rcyc, pc, rdo, eo, ns, na, st);
    vectors++;
    if (rc !== 4 || rdo !== d || eo !== 1'b0 || st !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_recover got cycle=%0d rdata=%h err=%0d stable=%0d want 4/%h/0/1", rc, rdo, eo, st, d);
    end
  endtask

  task automatic test_back_to_back();
    int rc1, rc2, t1, t2, pc, ns, na; logic [31:0] rdo1, rdo2, d1, d2; logic eo; bit st1, st2;
    sel = 1'b0;
    d1 = $urandom; d2 = $urandom;
    run_xfer(32'h100, 1'b0, 32'h0, 4'h0, 0, d1, 1'b0, 20, 1'b1, rc1, t1, pc, rdo1, eo, ns, na, st1);
    run_xfer(32'h104, 1'b0, 32'h0, 4'h0, 0, d2, 1'b0, 20, 1'b0, rc2, t2, pc, rdo2, eo, ns, na, st2);
    vectors++;
    if (t2 - t1 !== 4) begin miscompares++; $display("FAIL b2b_interval got %0d want 4", t2 - t1); end
    vectors++;
    if (st1 !== 1'b1 || st2 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_addr_order got stable1=%0d stable2=%0d want 1/1", st1, st2);
    end
    vectors++;
    if (rdo1 !== d1 || rdo2 !== d2) begin
      miscompares++;
      $display("FAIL b2b_rdata got %h,%h want %h,%h", rdo1, rdo2, d1, d2);
    end
  endtask

  task automatic test_random();
    int rc, rcyc, pc, ns, na, waits, exp_rc, exp_na; logic [31:0] rdo, a, wd, prd, exp_rd;
    logic eo, w, se, exp_err; logic [3:0] ws; bit st;
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom);
      waits = $urandom_range(0, 6);
      a = $urandom; wd = $urandom; prd = $urandom; ws = 4'($urandom);
      w = 1'($urandom); se = 1'($urandom);
      if (sel && waits >= 4) begin
        exp_rc = 6; exp_na = 4; exp_err = 1'b1; exp_rd = 32'h0;
      end else begin
        exp_rc = 3 + waits; exp_na = waits + 1; exp_err = se; exp_rd = w ? 32'h0 : prd;
      end
      run_xfer(a, w, wd, ws, waits, prd, se, 30, 1'b0, rc, rcyc, pc, rdo, eo, ns, na, st);
      vectors++;
      if (rc !== exp_rc) begin miscompares++; $display("FAIL rnd%0d_ready_cycle got %0d want %0d", i, rc, exp_rc); end
      vectors++;
      if (rdo !== exp_rd) begin miscompares++; $display("FAIL rnd%0d_rdata got %h want %h", i, rdo, exp_rd); end
      vectors++;
      if (eo !== exp_err) begin miscompares++; $display("FAIL rnd%0d_error got %0d want %0d", i, eo, exp_err); end
      vectors++;
      if (na !== exp_na) begin miscompares++; $display("FAIL rnd%0d_access got %0d want %0d", i, na, exp_na); end
      vectors++;
      if (st !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_bus_stable got %0d want 1", i, st); end
    end
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0;
    req_addr = '0; req_wdata = '0; req_write = 1'b0; req_wstrb = '0; req_valid = 1'b0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_zero_wait_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
